// File: rtl/ip_filter_pkg.sv
// Shared constants, field offsets and enumerations for the ingress drop filter.
package ip_filter_pkg;

    localparam logic [15:0] ETH_IPV4     = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL = 8'h45;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    // Bit offsets inside a 256-bit beat (byte k sits at [255-8k:248-8k]).
    localparam int DST_MAC_LSB   = 208;  // beat0 [255:208]
    localparam int ETHTYPE_LSB   = 144;  // beat0 [159:144]
    localparam int IP_HDR_MSB    = 143;  // beat0 [143:0] holds the first nine header words
    localparam int VER_IHL_LSB   = 136;  // beat0 [143:136]
    localparam int DST_IP_LSB    = 0;    // beat0 [15:0] upper half of destination IP
    localparam int LAST_WORD_LSB = 240;  // beat1 [255:240] tenth header word
    localparam int MCAST_BIT     = 40;   // group bit of a destination MAC

    typedef enum logic [2:0] {
        WAIT_B0,
        WAIT_B1,
        EMIT_B0,
        EMIT_B1,
        PASS,
        DROP
    } state_t;

    typedef enum logic [2:0] {
        RSN_NONE,
        RSN_RUNT,
        RSN_MAC,
        RSN_HDR,
        RSN_CSUM
    } reason_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout while !empty.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_W   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_W  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      wr_ok;
    logic                      rd_ok;

    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign dout        = mem[rd_ptr];
    assign full        = (depth == DEPTH_W);
    assign nearly_full = (depth >= NEARLY_W);
    assign empty       = (depth == '0);

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/ipv4_hdr_csum.sv
// One's-complement sum of the ten 16-bit IPv4 header words spread over two beats.
module ipv4_hdr_csum
    import ip_filter_pkg::*;
(
    input  logic [IP_HDR_MSB:0] hdr_beat0,
    input  logic [15:0]         hdr_last_word,
    output logic                csum_ok
);
    logic [19:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Ten-word sum fits in 20 bits, so two folds always absorb every carry.
    always_comb begin
        acc = {4'b0, hdr_last_word};
        for (int j = 0; j < 9; j++) begin
            acc = acc + {4'b0, hdr_beat0[IP_HDR_MSB - 16*j -: 16]};
        end
        fold1   = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
        fold2   = fold1[15:0] + {15'b0, fold1[16]};
        csum_ok = (fold2 == 16'hFFFF);
    end

endmodule

// File: rtl/ip_ingress_filter.sv
// Ingress drop filter: holds two beats, validates MAC/IPv4 header, forwards or discards.
module ip_ingress_filter
    import ip_filter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_PORT_POS         = 16,
    parameter int FIFO_DEPTH_BITS      = 4,
    parameter bit ACCEPT_MCAST         = 1'b1
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,
    input  logic [NUM_PORTS*48-1:0]           mac_table,
    input  logic [2:0]                        check_en,
    input  logic                              counter_clear,
    output logic [31:0]                       dropped_count,
    output logic [31:0]                       wrong_mac_count,
    output logic [31:0]                       bad_csum_count,
    output logic [31:0]                       bad_hdr_count,
    output logic [31:0]                       runt_count,
    output logic [31:0]                       last_dst_ip
);
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W = DW + SW + UW + 1;
    localparam int SRC_W  = 2 * NUM_PORTS;

    if (C_S_AXIS_DATA_WIDTH != 256) begin : g_bad_width
        $error("ip_ingress_filter supports only a 256-bit data path");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $error("ip_ingress_filter NUM_PORTS must be 1..8");
    end

    logic [DW-1:0] head_data;
    logic [SW-1:0] head_strb;
    logic [UW-1:0] head_user;
    logic          head_last;
    logic          fifo_empty;
    logic          fifo_nearly_full;
    logic          fifo_full;
    logic          pop;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (AXI_ACLK),
        .rst_n       (AXI_RESETN),
        .din         ({S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA}),
        .wr_en       (S_AXIS_TVALID && S_AXIS_TREADY),
        .rd_en       (pop),
        .dout        ({head_last, head_user, head_strb, head_data}),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign S_AXIS_TREADY = !fifo_nearly_full || !fifo_full && 1'b0;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] hold0_data, hold1_data;
    logic [SW-1:0] hold0_strb, hold1_strb;
    logic [UW-1:0] hold0_user, hold1_user;
    logic          hold0_last, hold1_last;

    // Verdict inputs: beat0 comes from hold0 once beat1 is at the head, else from the head.
    logic [47:0]         dst_mac;
    logic [15:0]         eth_type;
    logic [IP_HDR_MSB:0] ip_hdr0;
    logic [15:0]         ip_word9;
    logic [SRC_W-1:0]    src_bits;
    logic                single_beat;

    // Select which beat feeds the verdict; a single-beat packet has no tenth header word.
    always_comb begin
        if (state == WAIT_B1) begin
            dst_mac     = hold0_data[DST_MAC_LSB +: 48];
            eth_type    = hold0_data[ETHTYPE_LSB +: 16];
            ip_hdr0     = hold0_data[IP_HDR_MSB:0];
            src_bits    = hold0_user[SRC_PORT_POS +: SRC_W];
            ip_word9    = head_data[LAST_WORD_LSB +: 16];
            single_beat = 1'b0;
        end else begin
            dst_mac     = head_data[DST_MAC_LSB +: 48];
            eth_type    = head_data[ETHTYPE_LSB +: 16];
            ip_hdr0     = head_data[IP_HDR_MSB:0];
            src_bits    = head_user[SRC_PORT_POS +: SRC_W];
            ip_word9    = 16'h0000;
            single_beat = 1'b1;
        end
    end

    logic csum_ok;

    ipv4_hdr_csum u_csum (
        .hdr_beat0     (ip_hdr0),
        .hdr_last_word (ip_word9),
        .csum_ok       (csum_ok)
    );

    logic    port_hit;
    logic    from_cpu;
    logic    is_ipv4;
    logic    mac_ok;
    reason_t reason;

    // Match the destination MAC against the ingress port's entry; note CPU-sourced packets.
    always_comb begin
        port_hit = 1'b0;
        from_cpu = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (src_bits[2*i] && (dst_mac == mac_table[48*i +: 48])) port_hit = 1'b1;
            if (src_bits[2*i+1]) from_cpu = 1'b1;
        end
    end

    // Pick the single highest-priority drop reason: runt > MAC > header > checksum.
    always_comb begin
        is_ipv4 = (eth_type == ETH_IPV4);
        mac_ok  = port_hit || (dst_mac == BCAST_MAC) || (ACCEPT_MCAST && dst_mac[MCAST_BIT]);
        reason  = RSN_NONE;
        if (!from_cpu) begin
            if (check_en[2] && is_ipv4 && single_beat)                              reason = RSN_RUNT;
            else if (check_en[0] && !mac_ok)                                        reason = RSN_MAC;
            else if (check_en[1] && is_ipv4 && ip_hdr0[VER_IHL_LSB +: 8] != IPV4_VER_IHL) reason = RSN_HDR;
            else if (check_en[1] && is_ipv4 && !csum_ok)                            reason = RSN_CSUM;
        end
    end

    logic verdict_evt;
    assign verdict_evt = !fifo_empty && ((state == WAIT_B0 && head_last) || state == WAIT_B1);

    // Next state, FIFO pop and egress beat selection.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = head_data;
        M_AXIS_TSTRB  = head_strb;
        M_AXIS_TUSER  = head_user;
        M_AXIS_TLAST  = head_last;
        case (state)
            WAIT_B0: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (!head_last)             state_next = WAIT_B1;
                    else if (reason == RSN_NONE) state_next = EMIT_B0;
                    else                        state_next = WAIT_B0;
                end
            end
            WAIT_B1: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (reason == RSN_NONE) state_next = EMIT_B0;
                    else if (head_last)     state_next = WAIT_B0;
                    else                    state_next = DROP;
                end
            end
            EMIT_B0: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = hold0_data;
                M_AXIS_TSTRB  = hold0_strb;
                M_AXIS_TUSER  = hold0_user;
                M_AXIS_TLAST  = hold0_last;
                if (M_AXIS_TREADY) state_next = hold0_last ? WAIT_B0 : EMIT_B1;
            end
            EMIT_B1: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = hold1_data;
                M_AXIS_TSTRB  = hold1_strb;
                M_AXIS_TUSER  = hold1_user;
                M_AXIS_TLAST  = hold1_last;
                if (M_AXIS_TREADY) state_next = hold1_last ? WAIT_B0 : PASS;
            end
            PASS: begin
                M_AXIS_TVALID = !fifo_empty;
                pop           = M_AXIS_TREADY && !fifo_empty;
                if (pop && head_last) state_next = WAIT_B0;
            end
            DROP: begin
                pop = !fifo_empty;
                if (pop && head_last) state_next = WAIT_B0;
            end
            default: state_next = WAIT_B0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) state <= WAIT_B0;
        else             state <= state_next;
    end

    // Capture the first two beats of each packet as they pop.
    always_ff @(posedge AXI_ACLK) begin
        if (state == WAIT_B0 && pop) begin
            hold0_data <= head_data;
            hold0_strb <= head_strb;
            hold0_user <= head_user;
            hold0_last <= head_last;
        end
        if (state == WAIT_B1 && pop) begin
            hold1_data <= head_data;
            hold1_strb <= head_strb;
            hold1_user <= head_user;
            hold1_last <= head_last;
        end
    end

    // Drop counters and last forwarded destination IP; clear beats a same-cycle increment.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            dropped_count   <= '0;
            wrong_mac_count <= '0;
            bad_csum_count  <= '0;
            bad_hdr_count   <= '0;
            runt_count      <= '0;
            last_dst_ip     <= '0;
        end else begin
            if (verdict_evt && reason == RSN_NONE && is_ipv4) begin
                last_dst_ip <= {ip_hdr0[DST_IP_LSB +: 16], ip_word9};
            end
            if (counter_clear) begin
                dropped_count   <= '0;
                wrong_mac_count <= '0;
                bad_csum_count  <= '0;
                bad_hdr_count   <= '0;
                runt_count      <= '0;
            end else if (verdict_evt && reason != RSN_NONE) begin
                dropped_count <= dropped_count + 32'd1;
                case (reason)
                    RSN_RUNT: runt_count      <= runt_count + 32'd1;
                    RSN_MAC:  wrong_mac_count <= wrong_mac_count + 32'd1;
                    RSN_HDR:  bad_hdr_count   <= bad_hdr_count + 32'd1;
                    RSN_CSUM: bad_csum_count  <= bad_csum_count + 32'd1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ip_ingress_filter.sv
// Randomised self-checking bench for ip_ingress_filter with a packet-level reference model.
module tb_ip_ingress_filter;

    typedef struct packed {
        logic         last;
        logic [127:0] user;
        logic [31:0]  strb;
        logic [255:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] s_tdata = '0;
    logic [31:0]  s_tstrb = '0;
    logic [127:0] s_tuser = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic         s_tlast = 1'b0;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic         m_tlast;
    logic [191:0] mac_table;
    logic [2:0]   check_en = 3'b111;
    logic         counter_clear = 1'b0;
    logic [31:0]  dropped_count, wrong_mac_count, bad_csum_count, bad_hdr_count, runt_count;
    logic [31:0]  last_dst_ip;

    logic [47:0]  mac [4];
    int           cyc = 0;
    int           rdy_mode = 0;
    int           n_vec = 0;
    int           n_err = 0;

    beat_t        exp_q [$];
    beat_t        pkt [$];
    logic [15:0]  pkt_w9;
    int unsigned  e_drop, e_mac, e_csum, e_hdr, e_runt;
    logic [31:0]  exp_ip;
    int           lat_exp;
    int           first_vld_cyc;
    bit           stall_prev;
    beat_t        stall_beat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ip_ingress_filter dut (
        .AXI_ACLK        (clk),
        .AXI_RESETN      (rst_n),
        .S_AXIS_TDATA    (s_tdata),
        .S_AXIS_TSTRB    (s_tstrb),
        .S_AXIS_TUSER    (s_tuser),
        .S_AXIS_TVALID   (s_tvalid),
        .S_AXIS_TREADY   (s_tready),
        .S_AXIS_TLAST    (s_tlast),
        .M_AXIS_TDATA    (m_tdata),
        .M_AXIS_TSTRB    (m_tstrb),
        .M_AXIS_TUSER    (m_tuser),
        .M_AXIS_TVALID   (m_tvalid),
        .M_AXIS_TREADY   (m_tready),
        .M_AXIS_TLAST    (m_tlast),
        .mac_table       (mac_table),
        .check_en        (check_en),
        .counter_clear   (counter_clear),
        .dropped_count   (dropped_count),
        .wrong_mac_count (wrong_mac_count),
        .bad_csum_count  (bad_csum_count),
        .bad_hdr_count   (bad_hdr_count),
        .runt_count      (runt_count),
        .last_dst_ip     (last_dst_ip)
    );

    task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output readiness: always, random ~50%, or held off.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    // Egress monitor: scoreboard compare on handshake, stability check while stalled.
    always @(negedge clk) begin
        beat_t cur;
        cur = {m_tlast, m_tuser, m_tstrb, m_tdata};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else if (m_tvalid) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (stall_prev) chk("hold_stable", cur, stall_beat);
            if (m_tready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else                   chk("out_beat", cur, exp_q.pop_front());
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_beat = cur;
            end
        end else begin
            if (stall_prev) chk("valid_withdrawn", 0, 1);
            stall_prev = 1'b0;
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Plain one's-complement sum of the ten header words, folded until no carry remains.
    function automatic logic [15:0] ones_sum(input logic [255:0] b0, input logic [15:0] w9);
        int unsigned s;
        s = 32'(w9);
        for (int j = 0; j < 9; j++) s = s + 32'(b0[143 - 16*j -: 16]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic build_pkt(input int port, input bit cpu, input logic [47:0] dst,
                             input logic [15:0] et, input logic [7:0] vi, input bit bad,
                             input int nb);
        beat_t b;
        logic [15:0] s;
        pkt.delete();
        for (int k = 0; k < nb; k++) begin
            b.data = rnd256();
            b.strb = $urandom();
            b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.last = (k == nb - 1);
            pkt.push_back(b);
        end
        b = pkt[0];
        b.data[255:208] = dst;
        b.data[159:144] = et;
        b.data[143:136] = vi;
        b.data[63:48]   = 16'h0000;
        b.user[23:16]   = 8'h00;
        b.user[16 + 2*port + (cpu ? 1 : 0)] = 1'b1;
        pkt_w9 = (nb > 1) ? pkt[1].data[255:240] : 16'h0000;
        s = ones_sum(b.data, pkt_w9);
        b.data[63:48] = ~s ^ (bad ? 16'h0001 : 16'h0000);
        pkt[0] = b;
    endtask

    // Drop reason from the filter rules: 0 pass, 1 runt, 2 MAC, 3 header, 4 checksum.
    function automatic int ref_reason();
        logic [7:0]  src;
        logic [47:0] dst;
        bit          ipv4, ok;
        src  = pkt[0].user[23:16];
        dst  = pkt[0].data[255:208];
        ipv4 = (pkt[0].data[159:144] == 16'h0800);
        if ((src & 8'hAA) != 0) return 0;
        if (check_en[2] && ipv4 && pkt.size() == 1) return 1;
        if (check_en[0]) begin
            ok = (dst == 48'hFFFF_FFFF_FFFF) || dst[40];
            for (int i = 0; i < 4; i++) if (src[2*i] && dst == mac[i]) ok = 1'b1;
            if (!ok) return 2;
        end
        if (check_en[1] && ipv4) begin
            if (pkt[0].data[143:136] != 8'h45) return 3;
            if (ones_sum(pkt[0].data, pkt_w9) != 16'hFFFF) return 4;
        end
        return 0;
    endfunction

    task automatic model_pkt();
        int r;
        r = ref_reason();
        if (r == 0) begin
            foreach (pkt[k]) exp_q.push_back(pkt[k]);
            if (pkt[0].data[159:144] == 16'h0800) exp_ip = {pkt[0].data[15:0], pkt_w9};
        end else if (!counter_clear) begin
            e_drop++;
            case (r)
                1: e_runt++;
                2: e_mac++;
                3: e_hdr++;
                default: e_csum++;
            endcase
        end
    endtask

    task automatic send_pkt();
        int bound;
        foreach (pkt[k]) begin
            @(negedge clk);
            {s_tlast, s_tuser, s_tstrb, s_tdata} = pkt[k];
            s_tvalid = 1'b1;
            bound = 0;
            while (!s_tready) begin
                @(negedge clk);
                bound++;
                if (bound > 2000) begin
                    chk("s_tready_timeout", 0, 1);
                    s_tvalid = 1'b0;
                    return;
                end
            end
            if (k == 1) lat_exp = cyc + 2;
            @(posedge clk);
        end
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_dropped"}, dropped_count, e_drop);
        chk({tag, "_wrong_mac"}, wrong_mac_count, e_mac);
        chk({tag, "_bad_csum"}, bad_csum_count, e_csum);
        chk({tag, "_bad_hdr"}, bad_hdr_count, e_hdr);
        chk({tag, "_runt"}, runt_count, e_runt);
        chk({tag, "_last_dst_ip"}, last_dst_ip, exp_ip);
    endtask

    task automatic one(input string tag, input int port, input bit cpu, input logic [47:0] dst,
                       input bit bad, input int nb);
        build_pkt(port, cpu, dst, 16'h0800, 8'h45, bad, nb);
        model_pkt();
        send_pkt();
        drain(tag);
        chk_counters(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;
        int p, sel, nb, n;
        bit cpu, bad;
        logic [47:0] dst;
        logic [15:0] et;
        logic [7:0]  vi;

        mac[0] = 48'h02_00_00_00_00_10;
        mac[1] = 48'h02_00_00_00_00_21;
        mac[2] = 48'h02_00_00_00_00_32;
        mac[3] = 48'h02_00_00_00_00_43;
        for (int i = 0; i < 4; i++) mac_table[48*i +: 48] = mac[i];
        e_drop = 0; e_mac = 0; e_csum = 0; e_hdr = 0; e_runt = 0;
        exp_ip = '0;
        first_vld_cyc = 0;
        stall_prev = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_tready", s_tready, 1);
        chk_counters("reset");

        // Good 4-beat packet from port 0, with first-beat latency measured.
        first_vld_cyc = -1;
        one("good_p0", 0, 1'b0, mac[0], 1'b0, 4);
        chk("first_beat_latency", 32'(first_vld_cyc), 32'(lat_exp));

        one("bad_csum", 0, 1'b0, mac[0], 1'b1, 4);
        one("good_after_bad", 0, 1'b0, mac[0], 1'b0, 3);

        one("wrong_mac_p2", 2, 1'b0, 48'h00_11_22_33_44_55, 1'b0, 3);
        one("bcast_p2", 2, 1'b0, 48'hFF_FF_FF_FF_FF_FF, 1'b0, 3);
        one("mcast_p2", 2, 1'b0, 48'h01_00_5E_00_00_01, 1'b0, 2);

        one("runt_p1", 1, 1'b0, mac[1], 1'b0, 1);
        one("runt_cpu", 0, 1'b1, mac[1], 1'b0, 1);

        one("mac_and_csum", 3, 1'b0, 48'h00_11_22_33_44_55, 1'b1, 2);

        // Clear held across a dropping packet, so it overlaps the increment.
        @(negedge clk);
        counter_clear = 1'b1;
        e_drop = 0; e_mac = 0; e_csum = 0; e_hdr = 0; e_runt = 0;
        one("clear_vs_incr", 1, 1'b0, 48'h00_11_22_33_44_55, 1'b1, 3);
        @(negedge clk);
        counter_clear = 1'b0;

        // Random mixed traffic with ~50% egress stalls.
        rdy_mode = 1;
        for (int k = 0; k < 100; k++) begin
            p   = $urandom_range(0, 3);
            cpu = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            r64 = {$urandom(), $urandom()};
            if (sel < 5)       dst = mac[p];
            else if (sel == 5) dst = 48'hFF_FF_FF_FF_FF_FF;
            else if (sel == 6) dst = r64[47:0] | 48'h01_00_00_00_00_00;
            else               dst = r64[47:0] & ~48'h01_00_00_00_00_00;
            et  = ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800;
            vi  = ($urandom_range(0, 9) == 0) ? 8'h46 : 8'h45;
            bad = ($urandom_range(0, 4) == 0);
            nb  = $urandom_range(1, 5);
            build_pkt(p, cpu, dst, et, vi, bad, nb);
            model_pkt();
            send_pkt();
        end
        drain("random");
        chk_counters("random");

        // Make sure counters are non-zero, then reset mid-packet while egress is stalled.
        rdy_mode = 0;
        one("pre_reset_drop", 1, 1'b0, 48'h00_11_22_33_44_55, 1'b0, 2);
        rdy_mode = 2;
        build_pkt(0, 1'b0, mac[0], 16'h0800, 8'h45, 1'b0, 3);
        send_pkt();
        n = 0;
        while (!m_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stalled_tvalid", m_tvalid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_tvalid", m_tvalid, 0);
        exp_q.delete();
        e_drop = 0; e_mac = 0; e_csum = 0; e_hdr = 0; e_runt = 0;
        exp_ip = '0;
        chk_counters("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        one("after_reset", 2, 1'b0, mac[2], 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
